// File: rtl/mux_sel_arbiter.sv
// -----------------------------------------------------------------------------
// mux_sel_arbiter
//
// Round-robin arbiter for one shared 4:1 32-bit datapath mux. Four requesters
// compete for a single consumer. The winner's index drives the mux select, and
// the grant is held until the consumer reports completion or the owner drops
// its request. On release the arbiter hands the grant straight to the next
// requester in round-robin order, with no idle cycle in between.
//
// Optional feature (macro ARB_WDOG_EN):
//   When defined, a hold counter revokes any grant that stays active for
//   MAX_HOLD cycles without completion or abort. The revocation pulses
//   wdog_err for one cycle, and the revoked requester sits out that single
//   re-arbitration. When undefined, the counter is not built and wdog_err is 0.
//
// Parameters:
//   MAX_HOLD  cycles a single grant may stay active under the watchdog (1..255)
//   CNT_W     hold counter width; 2**CNT_W must exceed MAX_HOLD
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   req[3:0]  level requests, bit i = requester i
//   done      consumer finishes the current transfer this cycle
//   gnt[3:0]  registered one-hot grant, zero when idle
//   sel[1:0]  registered mux select, index of the granted requester;
//             keeps its last value while idle
//   busy      registered, high while a grant is active
//   wdog_err  registered one-cycle pulse when the watchdog revokes a grant
// -----------------------------------------------------------------------------
module mux_sel_arbiter #(
    parameter int MAX_HOLD = 15,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       busy,
    output logic       wdog_err
);

    // Elaboration-time parameter sanity check.
    if (MAX_HOLD < 1 || MAX_HOLD > 255 || (2 ** CNT_W) <= MAX_HOLD) begin : g_bad_cfg
        $error("mux_sel_arbiter: MAX_HOLD must be 1..255 and below 2**CNT_W");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state, state_nx;
    logic [1:0] last, last_nx;
    logic [3:0] gnt_nx;
    logic [1:0] sel_nx;
    logic       busy_nx;

    logic       owner_req;
    logic       trip;        // watchdog revocation this cycle
    logic       release_now; // current grant ends on this edge
    logic [3:0] cand;        // requests eligible for the next arbitration
    logic [2:0] pick;        // {found, index}
    logic       start_grant; // a new grant is loaded on this edge

    // Round-robin search starting at (l + 1) mod 4. The loop runs from the
    // lowest priority to the highest, so the highest-priority hit is written
    // last and wins.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] l);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            idx = l + 2'(k);
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    // While a grant is active, last always equals the owner's index.
    assign owner_req   = req[last];
    assign release_now = (state == GRANT) && (done || !owner_req || trip);
    // A revoked owner is masked out for this one arbitration only.
    assign cand        = trip ? (req & ~(4'b0001 << last)) : req;
    assign pick        = rr_pick(cand, last);

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_nx    = state;
        last_nx     = last;
        gnt_nx      = gnt;
        sel_nx      = sel;
        busy_nx     = busy;
        start_grant = 1'b0;

        unique case (state)
            IDLE: begin
                // In IDLE there is no trip, so cand equals req.
                if (pick[2]) begin
                    start_grant = 1'b1;
                end
            end
            GRANT: begin
                if (release_now) begin
                    if (pick[2]) begin
                        start_grant = 1'b1;
                    end else begin
                        state_nx = IDLE;
                        gnt_nx   = 4'b0000;
                        busy_nx  = 1'b0;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        if (start_grant) begin
            state_nx = GRANT;
            last_nx  = pick[1:0];
            sel_nx   = pick[1:0];
            gnt_nx   = 4'b0001 << pick[1:0];
            busy_nx  = 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            last  <= 2'd3;
            gnt   <= 4'b0000;
            sel   <= 2'd0;
            busy  <= 1'b0;
        end else begin
            state <= state_nx;
            last  <= last_nx;
            gnt   <= gnt_nx;
            sel   <= sel_nx;
            busy  <= busy_nx;
        end
    end

`ifdef ARB_WDOG_EN
    // The counter is 0 on the first cycle of a grant. Tripping when it holds
    // MAX_HOLD-1 means the counter reaches MAX_HOLD on the revoking edge, so a
    // grant lasts exactly MAX_HOLD cycles.
    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [CNT_W-1:0] hold_cnt;

    assign trip = (state == GRANT) && !done && owner_req && (hold_cnt == HOLD_LIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
            wdog_err <= 1'b0;
        end else begin
            wdog_err <= trip;
            if (start_grant || state != GRANT) begin
                hold_cnt <= '0;
            end else if (hold_cnt != CNT_MAX) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end
`else
    assign trip     = 1'b0;
    assign wdog_err = 1'b0;
`endif

endmodule
